// File: rtl/call_result_collector.sv
// call_result_collector: issues a batch of callee requests and
// accumulates the signed 32-bit returns into a 40-bit running sum.
module call_result_collector #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        i_start,
    input  logic [7:0]  i_count,
    output logic        o_callee_req,
    input  logic        i_callee_busy,
    input  logic [31:0] i_callee_return,
    output logic        o_busy,
    output logic        o_done,
    output logic [39:0] o_sum,
    output logic [31:0] o_last,
    output logic [7:0]  o_calls,
    output logic        o_error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LO,
        S_ACC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [39:0]   sum_q, sum_d;
    logic [31:0]   last_q, last_d;
    logic [7:0]    calls_q, calls_d;
    logic          err_q, err_d;

    // Next-state logic; the registered flags are derived from the
    // next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        sum_d   = sum_q;
        last_d  = last_q;
        calls_d = calls_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    sum_d   = '0;
                    calls_d = '0;
                    err_d   = 1'b0;
                    rem_d   = i_count;
                    tmo_d   = '0;
                    state_d = (i_count == 8'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (i_callee_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT_LO: begin
                if (!i_callee_busy) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                sum_d   = sum_q + {{8{i_callee_return[31]}}, i_callee_return};
                last_d  = i_callee_return;
                calls_d = calls_q + 8'd1;
                rem_d   = rem_q - 8'd1;
                tmo_d   = '0;
                state_d = (rem_q == 8'd1) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset wins over the clock enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            last_q  <= '0;
            calls_q <= '0;
            err_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            calls_q <= calls_d;
            err_q   <= err_d;
        end
    end

    assign o_callee_req = req_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_sum        = sum_q;
    assign o_last       = last_q;
    assign o_calls      = calls_q;
    assign o_error      = err_q;

endmodule

// File: tb/tb_call_result_collector.sv
// tb_call_result_collector: directed and randomized batches against
// a callee model, with a sum/last/count reference computed per batch.
module tb_call_result_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_count = 8'd0;
    logic        o_callee_req;
    logic        i_callee_busy = 1'b0;
    logic [31:0] i_callee_return = 32'd0;
    logic        o_busy;
    logic        o_done;
    logic [39:0] o_sum;
    logic [31:0] o_last;
    logic [7:0]  o_calls;
    logic        o_error;

    call_result_collector #(.TIMEOUT(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .ce             (ce),
        .i_start        (i_start),
        .i_count        (i_count),
        .o_callee_req   (o_callee_req),
        .i_callee_busy  (i_callee_busy),
        .i_callee_return(i_callee_return),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_sum          (o_sum),
        .o_last         (o_last),
        .o_calls        (o_calls),
        .o_error        (o_error)
    );

    always #5 clock = ~clock;

    int npass = 0;
    int ntotal = 0;

    logic [31:0] rets [0:4095];
    int   cal_idx = 0;
    int   cal_cnt = 0;
    logic cal_active = 1'b0;
    int   busy_len = 6;
    bit   never_busy = 1'b0;
    bit   ce_tog = 1'b0;

    int   done_cnt = 0;
    int   req_cyc = 0;
    int   req_rise = 0;
    logic req_prev = 1'b0;

    logic [39:0] exp_sum;
    logic [31:0] exp_last;

    // Callee: raises busy for busy_len cycles per accepted request.
    always @(posedge clock) begin
        if (reset) begin
            cal_active    <= 1'b0;
            i_callee_busy <= 1'b0;
        end else if (cal_active) begin
            if (cal_cnt <= 1) begin
                i_callee_busy <= 1'b0;
                cal_active    <= 1'b0;
            end
            cal_cnt <= cal_cnt - 1;
        end else if (o_callee_req && !never_busy) begin
            cal_active      <= 1'b1;
            i_callee_busy   <= 1'b1;
            cal_cnt         <= busy_len;
            i_callee_return <= rets[cal_idx % 4096];
            cal_idx         <= cal_idx + 1;
        end
    end

    // Clock enable: either steady high or toggling each cycle.
    always @(posedge clock) begin
        #1;
        ce = ce_tog ? ~ce : 1'b1;
    end

    // Monitor: enabled done cycles, enabled req cycles, req pulses.
    always @(negedge clock) begin
        if (o_done && ce && !reset) done_cnt++;
        if (o_callee_req && ce) req_cyc++;
        if (o_callee_req && !req_prev) req_rise++;
        req_prev = o_callee_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Store n return values for the next calls and build the reference.
    // mode 0: constant v, 1: random, 2: explicit list a,b.
    task automatic fill(input int n, input int mode, input logic [31:0] v,
                        input logic [31:0] b);
        longint s;
        logic [31:0] x;
        s = 0;
        x = 32'd0;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0: x = v;
                1: x = $urandom;
                default: x = (k == 0) ? v : b;
            endcase
            rets[(cal_idx + k) % 4096] = x;
            s += longint'($signed(x));
        end
        exp_sum = s[39:0];
        exp_last = x;
    endtask

    task automatic start_batch(input int n);
        @(negedge clock);
        i_start = 1'b1;
        i_count = 8'(n);
        for (int k = 0; k < 50 && !o_busy; k++) @(negedge clock);
        chk("start_accept", 64'(o_busy), 64'd1);
        i_start = 1'b0;
    endtask

    task automatic finish_batch(input bit scramble);
        int cyc;
        cyc = 0;
        while (o_busy && cyc < 5000) begin
            if (scramble) begin
                i_start = 1'($urandom);
                i_count = 8'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        i_start = 1'b0;
        chk("batch_end_in_budget", 64'(cyc < 5000), 64'd1);
    endtask

    task automatic check_result(input string tag, input int n,
                                input bit err);
        chk({tag, "_sum"}, 64'(o_sum), 64'(exp_sum));
        chk({tag, "_calls"}, 64'(o_calls), 64'(n));
        chk({tag, "_error"}, 64'(o_error), 64'(err));
        if (n > 0) chk({tag, "_last"}, 64'(o_last), 64'(exp_last));
    endtask

    initial begin
        int d0, r0, c0, n;
        repeat (3) @(negedge clock);
        chk("rst_req", 64'(o_callee_req), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_sum", 64'(o_sum), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_calls", 64'(o_calls), 64'd0);
        chk("rst_error", 64'(o_error), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Three calls returning 2290 each.
        busy_len = 6;
        fill(3, 0, 32'd2290, 32'd0);
        d0 = done_cnt; r0 = req_rise;
        start_batch(3);
        finish_batch(1'b0);
        check_result("basic", 3, 1'b0);
        chk("basic_sum_const", 64'(o_sum), 64'd6870);
        chk("basic_done", 64'(done_cnt - d0), 64'd1);
        chk("basic_reqs", 64'(req_rise - r0), 64'd3);

        // Empty batch: straight to DONE, no request.
        d0 = done_cnt; r0 = req_rise;
        exp_sum = 40'd0;
        start_batch(0);
        chk("zero_done_now", 64'(o_done), 64'd1);
        finish_batch(1'b0);
        check_result("zero", 0, 1'b0);
        chk("zero_done", 64'(done_cnt - d0), 64'd1);
        chk("zero_reqs", 64'(req_rise - r0), 64'd0);

        // Callee never answers: timeout after 16 request cycles.
        never_busy = 1'b1;
        d0 = done_cnt; r0 = req_rise; c0 = req_cyc;
        exp_sum = 40'd0;
        start_batch(2);
        finish_batch(1'b0);
        check_result("tmo", 0, 1'b1);
        chk("tmo_req_cycles", 64'(req_cyc - c0), 64'd16);
        chk("tmo_reqs", 64'(req_rise - r0), 64'd1);
        chk("tmo_done", 64'(done_cnt - d0), 64'd1);
        never_busy = 1'b0;

        // Signed returns -5 then 7; error must clear on start.
        busy_len = 2;
        fill(2, 2, -32'sd5, 32'd7);
        start_batch(2);
        finish_batch(1'b0);
        check_result("signed", 2, 1'b0);
        chk("signed_sum_const", 64'(o_sum), 64'h2);

        // Clock enable toggling every cycle.
        busy_len = 6;
        fill(3, 0, 32'd2290, 32'd0);
        d0 = done_cnt;
        ce_tog = 1'b1;
        start_batch(3);
        finish_batch(1'b0);
        ce_tog = 1'b0;
        repeat (2) @(negedge clock);
        check_result("ce", 3, 1'b0);
        chk("ce_done", 64'(done_cnt - d0), 64'd1);

        // Two maximal batches of the most negative return.
        busy_len = 1;
        for (int b = 0; b < 2; b++) begin
            fill(255, 0, 32'h8000_0000, 32'd0);
            start_batch(255);
            finish_batch(1'b0);
            check_result("bigneg", 255, 1'b0);
            chk("bigneg_sign", 64'(o_sum[39]), 64'd1);
        end

        // Random batches with start/count noise during the batch.
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 12);
            busy_len = $urandom_range(1, 5);
            fill(n, 1, 32'd0, 32'd0);
            d0 = done_cnt; r0 = req_rise;
            start_batch(n);
            finish_batch(1'b1);
            check_result("rand", n, 1'b0);
            chk("rand_done", 64'(done_cnt - d0), 64'd1);
            chk("rand_reqs", 64'(req_rise - r0), 64'(n));
        end

        // Reset while waiting on the second call.
        busy_len = 6;
        fill(3, 0, 32'd100, 32'd0);
        d0 = done_cnt;
        start_batch(3);
        n = 0;
        while (!(o_calls == 8'd1 && !o_callee_req && i_callee_busy)
               && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("rst_mid_reached", 64'(n < 200), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rstm_req", 64'(o_callee_req), 64'd0);
        chk("rstm_busy", 64'(o_busy), 64'd0);
        chk("rstm_sum", 64'(o_sum), 64'd0);
        chk("rstm_last", 64'(o_last), 64'd0);
        chk("rstm_calls", 64'(o_calls), 64'd0);
        chk("rstm_done", 64'(o_done), 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("rstm_no_done", 64'(done_cnt - d0), 64'd0);
        fill(3, 2, 32'd11, 32'd22);
        start_batch(3);
        finish_batch(1'b0);
        check_result("after_rst", 3, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
